// File: rtl/bcp_feeder.sv
// Clause-sweep feeder for a BCP processing element: holds the clause store, walks it once
// per decision literal, writes back pruned clauses and queues implied literals in a FIFO.
module bcp_feeder #(
   parameter int CLA_LENGTH    = 3,
   parameter int LIT_INDEX_MAX = 15,
   parameter int NUM_CLA       = 4,
   parameter int IMP_DEPTH     = 4,
   localparam int LW = $clog2(LIT_INDEX_MAX) + 1,
   localparam int CW = CLA_LENGTH * LW,
   localparam int IW = $clog2(NUM_CLA)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cla_wr_en,
   input  logic [IW-1:0]        cla_wr_idx,
   input  logic [CW-1:0]        cla_wr_data,
   input  logic                 dec_valid,
   input  logic signed [LW-1:0] dec_lit,
   output logic                 dec_ready,
   output logic signed [LW-1:0] pe_litDec,
   output logic [CW-1:0]        pe_clause,
   input  logic                 pe_imply,
   input  logic signed [LW-1:0] pe_imply_idx,
   input  logic [CW-1:0]        pe_pr_clause,
   input  logic                 pe_done,
   input  logic                 pe_conflict,
   output logic                 imp_valid,
   output logic signed [LW-1:0] imp_lit,
   input  logic                 imp_ready,
   output logic                 busy,
   output logic                 conflict,
   output logic                 sweep_done,
   output logic [IW-1:0]        conflict_idx,
   input  logic                 conflict_clr
);

   localparam int PW   = (IMP_DEPTH > 1) ? $clog2(IMP_DEPTH) : 1;
   localparam int CNTW = $clog2(IMP_DEPTH + 1);
   localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_CLA - 1);
   localparam logic [PW-1:0]   LAST_PTR = PW'(IMP_DEPTH - 1);
   localparam logic [CNTW-1:0] FULL_CNT = CNTW'(IMP_DEPTH);

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, CONFLICT} state_t;

   state_t state, state_d;

   logic [CW-1:0]        store [NUM_CLA];
   logic [NUM_CLA-1:0]   sat;
   logic [IW-1:0]        idx;
   logic signed [LW-1:0] lit_q;

   logic signed [LW-1:0] fifo_mem [IMP_DEPTH];
   logic [PW-1:0]        rd_ptr, wr_ptr;
   logic [CNTW-1:0]      count;

   logic load_en, latch_dec, advance, writeback, set_sat, push, pop;
   logic take_conflict, flush, done_d, fifo_full, stall;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign imp_valid = (count != '0);
   assign imp_lit   = fifo_mem[rd_ptr];
   assign pop       = imp_valid && imp_ready;
   assign fifo_full = (count == FULL_CNT);
   // A full FIFO only blocks an implying clause if nothing leaves the FIFO this cycle.
   assign stall     = pe_imply && fifo_full && !pop;

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      state_d       = state;
      load_en       = 1'b0;
      latch_dec     = 1'b0;
      advance       = 1'b0;
      writeback     = 1'b0;
      set_sat       = 1'b0;
      push          = 1'b0;
      take_conflict = 1'b0;
      flush         = 1'b0;
      done_d        = 1'b0;
      dec_ready     = 1'b0;
      busy          = 1'b1;
      conflict      = 1'b0;
      pe_litDec     = '0;
      pe_clause     = '0;
      case (state)
         IDLE: begin
            dec_ready = 1'b1;
            busy      = 1'b0;
            load_en   = cla_wr_en;
            if (dec_valid) begin
               if (dec_lit != '0) begin
                  latch_dec = 1'b1;
                  state_d   = SWEEP;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         SWEEP: begin
            pe_litDec = lit_q;
            pe_clause = store[idx];
            if (sat[idx]) begin
               advance = 1'b1;
            end else if (pe_conflict) begin
               take_conflict = 1'b1;
               state_d       = CONFLICT;
            end else if (!stall) begin
               writeback = 1'b1;
               set_sat   = pe_done;
               push      = pe_imply;
               advance   = 1'b1;
            end
            if (advance && (idx == LAST_IDX)) state_d = DRAIN;
         end
         DRAIN: begin
            if (count == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         CONFLICT: begin
            conflict = 1'b1;
            if (conflict_clr) begin
               flush   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CLA; i++) store[i] <= '0;
         sat          <= '0;
         idx          <= '0;
         lit_q        <= '0;
         conflict_idx <= '0;
         sweep_done   <= 1'b0;
      end else begin
         sweep_done <= done_d;
         if (latch_dec) begin
            lit_q <= dec_lit;
            idx   <= '0;
         end
         if (load_en) begin
            store[cla_wr_idx] <= cla_wr_data;
            sat[cla_wr_idx]   <= 1'b0;
         end
         if (writeback)     store[idx]   <= pe_pr_clause;
         if (set_sat)       sat[idx]     <= 1'b1;
         if (take_conflict) conflict_idx <= idx;
         if (advance && (idx != LAST_IDX)) idx <= idx + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: FIFO storage carries no reset; occupancy is tracked by count, so stale slots are never visible as valid.
   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= pe_imply_idx;
   end

endmodule

// File: tb/tb_bcp_feeder.sv
// Bench for bcp_feeder: two instances (4-entry store and a 5-entry store) each driven by a
// behavioural PE model; implied literals are checked against a scoreboard queue.
module tb_bcp_feeder;

   localparam int LW = 5;
   localparam int CW = 3 * LW;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // instance A: default parameters
   logic                 a_cla_wr_en = 1'b0;
   logic [1:0]           a_cla_wr_idx = '0;
   logic [CW-1:0]        a_cla_wr_data = '0;
   logic                 a_dec_valid = 1'b0;
   logic signed [LW-1:0] a_dec_lit = '0;
   logic                 a_dec_ready;
   logic signed [LW-1:0] a_pe_litDec;
   logic [CW-1:0]        a_pe_clause;
   logic                 a_pe_imply, a_pe_done, a_pe_conflict;
   logic signed [LW-1:0] a_pe_imply_idx;
   logic [CW-1:0]        a_pe_pr_clause;
   logic                 a_imp_valid;
   logic signed [LW-1:0] a_imp_lit;
   logic                 a_imp_ready = 1'b1;
   logic                 a_busy, a_conflict, a_sweep_done;
   logic [1:0]           a_conflict_idx;
   logic                 a_conflict_clr = 1'b0;

   // instance B: five clauses, four-deep FIFO
   logic                 b_cla_wr_en = 1'b0;
   logic [2:0]           b_cla_wr_idx = '0;
   logic [CW-1:0]        b_cla_wr_data = '0;
   logic                 b_dec_valid = 1'b0;
   logic signed [LW-1:0] b_dec_lit = '0;
   logic                 b_dec_ready;
   logic signed [LW-1:0] b_pe_litDec;
   logic [CW-1:0]        b_pe_clause;
   logic                 b_pe_imply, b_pe_done, b_pe_conflict;
   logic signed [LW-1:0] b_pe_imply_idx;
   logic [CW-1:0]        b_pe_pr_clause;
   logic                 b_imp_valid;
   logic signed [LW-1:0] b_imp_lit;
   logic                 b_imp_ready = 1'b0;
   logic                 b_busy, b_conflict, b_sweep_done;
   logic [2:0]           b_conflict_idx;
   logic                 b_conflict_clr = 1'b0;

   bcp_feeder u_a (
      .clock(clock), .reset(reset),
      .cla_wr_en(a_cla_wr_en), .cla_wr_idx(a_cla_wr_idx), .cla_wr_data(a_cla_wr_data),
      .dec_valid(a_dec_valid), .dec_lit(a_dec_lit), .dec_ready(a_dec_ready),
      .pe_litDec(a_pe_litDec), .pe_clause(a_pe_clause),
      .pe_imply(a_pe_imply), .pe_imply_idx(a_pe_imply_idx), .pe_pr_clause(a_pe_pr_clause),
      .pe_done(a_pe_done), .pe_conflict(a_pe_conflict),
      .imp_valid(a_imp_valid), .imp_lit(a_imp_lit), .imp_ready(a_imp_ready),
      .busy(a_busy), .conflict(a_conflict), .sweep_done(a_sweep_done),
      .conflict_idx(a_conflict_idx), .conflict_clr(a_conflict_clr)
   );

   bcp_feeder #(.NUM_CLA(5), .IMP_DEPTH(4)) u_b (
      .clock(clock), .reset(reset),
      .cla_wr_en(b_cla_wr_en), .cla_wr_idx(b_cla_wr_idx), .cla_wr_data(b_cla_wr_data),
      .dec_valid(b_dec_valid), .dec_lit(b_dec_lit), .dec_ready(b_dec_ready),
      .pe_litDec(b_pe_litDec), .pe_clause(b_pe_clause),
      .pe_imply(b_pe_imply), .pe_imply_idx(b_pe_imply_idx), .pe_pr_clause(b_pe_pr_clause),
      .pe_done(b_pe_done), .pe_conflict(b_pe_conflict),
      .imp_valid(b_imp_valid), .imp_lit(b_imp_lit), .imp_ready(b_imp_ready),
      .busy(b_busy), .conflict(b_conflict), .sweep_done(b_sweep_done),
      .conflict_idx(b_conflict_idx), .conflict_clr(b_conflict_clr)
   );

   typedef struct packed {
      logic                 imply;
      logic signed [LW-1:0] lit;
      logic [CW-1:0]        pr;
      logic                 done;
      logic                 conflict;
   } pe_res_t;

   // Behavioural PE: satisfied clause -> done; literals of opposite polarity are pruned;
   // a pruned clause left with one literal implies it, with none it conflicts.
   function automatic pe_res_t pe_model(input logic signed [LW-1:0] d, input logic [CW-1:0] c);
      pe_res_t r;
      logic sat_hit, pruned;
      int live;
      logic signed [LW-1:0] l, last;
      r = '0; r.pr = c; sat_hit = 1'b0; pruned = 1'b0; live = 0; last = '0;
      for (int i = 0; i < 3; i++) begin
         l = c[i*LW +: LW];
         if (l != '0) begin
            if (l == d) sat_hit = 1'b1;
            else if (l == -d) begin
               pruned = 1'b1;
               r.pr[i*LW +: LW] = '0;
            end else begin
               live++;
               last = l;
            end
         end
      end
      if (sat_hit) begin
         r.pr   = c;
         r.done = 1'b1;
      end else if (pruned) begin
         r.conflict = (live == 0);
         r.imply    = (live == 1);
         r.lit      = last;
      end
      return r;
   endfunction

   pe_res_t a_res, b_res;
   always_comb a_res = pe_model(a_pe_litDec, a_pe_clause);
   always_comb b_res = pe_model(b_pe_litDec, b_pe_clause);
   assign a_pe_imply = a_res.imply;    assign a_pe_imply_idx = a_res.lit;
   assign a_pe_pr_clause = a_res.pr;   assign a_pe_done = a_res.done;
   assign a_pe_conflict = a_res.conflict;
   assign b_pe_imply = b_res.imply;    assign b_pe_imply_idx = b_res.lit;
   assign b_pe_pr_clause = b_res.pr;   assign b_pe_done = b_res.done;
   assign b_pe_conflict = b_res.conflict;

   function automatic logic [CW-1:0] cla(input int s0, input int s1, input int s2);
      return {LW'(s2), LW'(s1), LW'(s0)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard of implied literals, compared when each FIFO pop is observed
   logic signed [LW-1:0] qa[$], qb[$];
   logic signed [LW-1:0] ea, eb;

   always begin
      @(negedge clock);
      #2;
      if (a_imp_valid && a_imp_ready) begin
         if (qa.size() != 0) ea = qa.pop_front();
         else ea = 'x;
         check("imp_a_lit", a_imp_lit, ea);
      end
      if (b_imp_valid && b_imp_ready) begin
         if (qb.size() != 0) eb = qb.pop_front();
         else eb = 'x;
         check("imp_b_lit", b_imp_lit, eb);
      end
   end

   // drive tasks are entered on a falling edge and return on the next one
   task automatic load(input bit use_b, input int i, input logic [CW-1:0] d);
      if (use_b) begin b_cla_wr_en = 1'b1; b_cla_wr_idx = 3'(i); b_cla_wr_data = d; end
      else       begin a_cla_wr_en = 1'b1; a_cla_wr_idx = 2'(i); a_cla_wr_data = d; end
      @(negedge clock);
      a_cla_wr_en = 1'b0;
      b_cla_wr_en = 1'b0;
   endtask

   task automatic decide(input bit use_b, input int lit);
      if (use_b) begin b_dec_valid = 1'b1; b_dec_lit = LW'(lit); end
      else       begin a_dec_valid = 1'b1; a_dec_lit = LW'(lit); end
      @(negedge clock);
      a_dec_valid = 1'b0; a_dec_lit = '0;
      b_dec_valid = 1'b0; b_dec_lit = '0;
   endtask

   task automatic expect_sw(input bit use_b, input string tag, input int lit, input logic [CW-1:0] c);
      check({tag, "_busy"}, use_b ? b_busy : a_busy, 1);
      check({tag, "_rdy"}, use_b ? b_dec_ready : a_dec_ready, 0);
      check({tag, "_lit"}, use_b ? b_pe_litDec : a_pe_litDec, lit);
      check({tag, "_cla"}, use_b ? b_pe_clause : a_pe_clause, c);
      @(negedge clock);
   endtask

   task automatic wait_done(input bit use_b, input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         if (use_b ? b_sweep_done : a_sweep_done) seen = 1;
         else @(negedge clock);
      end
      check({tag, "_seen"}, seen, 1);
      @(negedge clock);
      check({tag, "_pulse"}, use_b ? b_sweep_done : a_sweep_done, 0);
      check({tag, "_idle"}, use_b ? b_dec_ready : a_dec_ready, 1);
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, "_busy"}, a_busy, 0);
      check({tag, "_rdy"}, a_dec_ready, 1);
      check({tag, "_cfl"}, a_conflict, 0);
      check({tag, "_cidx"}, a_conflict_idx, 0);
      check({tag, "_done"}, a_sweep_done, 0);
      check({tag, "_ivld"}, a_imp_valid, 0);
      check({tag, "_plit"}, a_pe_litDec, 0);
      check({tag, "_pcla"}, a_pe_clause, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 reset = 1'b1;
      @(negedge clock);
      check_reset_a("rst");
      check("rst_b_rdy", b_dec_ready, 1);
      check("rst_b_busy", b_busy, 0);
      reset = 1'b0;
      @(negedge clock);

      // first decision: entry0 satisfied, entry1 implies 3; loads during the sweep are ignored
      load(0, 0, cla(1, 2, 0));
      load(0, 1, cla(-1, 3, 0));
      load(0, 2, cla(-2, -3, 0));
      load(0, 3, cla(4, 0, 0));
      qa.push_back(LW'(3));
      decide(0, 1);
      a_cla_wr_en = 1'b1; a_cla_wr_idx = 2'd3; a_cla_wr_data = cla(9, 9, 9);
      expect_sw(0, "s1_0", 1, cla(1, 2, 0));
      expect_sw(0, "s1_1", 1, cla(-1, 3, 0));
      expect_sw(0, "s1_2", 1, cla(-2, -3, 0));
      expect_sw(0, "s1_3", 1, cla(4, 0, 0));
      a_cla_wr_en = 1'b0;
      check("s1_drain_busy", a_busy, 1);
      check("s1_drain_pcla", a_pe_clause, 0);
      wait_done(0, "s1_done");

      // second decision: sat entry0 must be skipped, entry1 appears pruned
      decide(0, -2);
      expect_sw(0, "s2_0", -2, cla(1, 2, 0));
      expect_sw(0, "s2_1", -2, cla(0, 3, 0));
      expect_sw(0, "s2_2", -2, cla(-2, -3, 0));
      expect_sw(0, "s2_3", -2, cla(4, 0, 0));
      wait_done(0, "s2_done");

      // third decision: nothing was written back to the skipped entry
      decide(0, 5);
      expect_sw(0, "s3_0", 5, cla(1, 2, 0));
      expect_sw(0, "s3_1", 5, cla(0, 3, 0));
      expect_sw(0, "s3_2", 5, cla(-2, -3, 0));
      expect_sw(0, "s3_3", 5, cla(4, 0, 0));
      wait_done(0, "s3_done");

      // zero decision literal: handshake only, sweep_done on the next cycle
      a_dec_valid = 1'b1; a_dec_lit = '0;
      check("z_rdy", a_dec_ready, 1);
      @(negedge clock);
      a_dec_valid = 1'b0;
      check("z_done", a_sweep_done, 1);
      check("z_busy", a_busy, 0);
      @(negedge clock);
      check("z_pulse", a_sweep_done, 0);

      // conflict at entry2 with one implied literal waiting in the FIFO
      a_imp_ready = 1'b0;
      load(0, 0, cla(1, 0, 0));
      load(0, 1, cla(-1, 7, 0));
      load(0, 2, cla(-1, 0, 0));
      load(0, 3, cla(1, 6, 0));
      decide(0, 1);
      expect_sw(0, "c_0", 1, cla(1, 0, 0));
      expect_sw(0, "c_1", 1, cla(-1, 7, 0));
      expect_sw(0, "c_2", 1, cla(-1, 0, 0));
      check("c_pcla", a_pe_clause, 0);
      check("c_ivld", a_imp_valid, 1);
      check("c_ilit", a_imp_lit, 7);
      for (int k = 0; k < 3; k++) begin
         check("c_cfl", a_conflict, 1);
         check("c_cidx", a_conflict_idx, 2);
         check("c_busy", a_busy, 1);
         @(negedge clock);
      end
      a_conflict_clr = 1'b1;
      @(negedge clock);
      a_conflict_clr = 1'b0;
      check("clr_cfl", a_conflict, 0);
      check("clr_busy", a_busy, 0);
      check("clr_ivld", a_imp_valid, 0);
      check("clr_rdy", a_dec_ready, 1);

      // reset in the middle of a sweep with two FIFO entries
      load(0, 0, cla(-1, 8, 0));
      load(0, 1, cla(-1, 9, 0));
      load(0, 2, cla(2, 0, 0));
      load(0, 3, cla(3, 0, 0));
      decide(0, 1);
      expect_sw(0, "r_0", 1, cla(-1, 8, 0));
      expect_sw(0, "r_1", 1, cla(-1, 9, 0));
      check("r_2_cla", a_pe_clause, cla(2, 0, 0));
      check("r_2_ivld", a_imp_valid, 1);
      #3 reset = 1'b1;
      #1 check_reset_a("async");
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_reset_a("post");
      decide(0, 5);
      for (int i = 0; i < 4; i++) expect_sw(0, "r_clr", 5, cla(0, 0, 0));
      wait_done(0, "r_done");
      a_imp_ready = 1'b1;

      // five implying clauses into a four-deep FIFO with the consumer stalled
      for (int i = 0; i < 5; i++) begin
         load(1, i, cla(-1, 10 + i, 0));
         qb.push_back(LW'(10 + i));
      end
      decide(1, 1);
      for (int i = 0; i < 4; i++) expect_sw(1, "f", 1, cla(-1, 10 + i, 0));
      check("f_head", b_imp_lit, 10);
      for (int k = 0; k < 4; k++) begin
         check("f_stall_cla", b_pe_clause, cla(-1, 14, 0));
         check("f_stall_busy", b_busy, 1);
         check("f_stall_ivld", b_imp_valid, 1);
         @(negedge clock);
      end
      b_imp_ready = 1'b1;
      wait_done(1, "f_done");
      check("f_qb_empty", qb.size(), 0);
      check("qa_empty", qa.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcp_feeder.md
BCP_FEEDER -- requirements
Module: bcp_feeder

Interface
REQ-001 Parameters (name, default, meaning): CLA_LENGTH, 3, literal slots per clause; LIT_INDEX_MAX, 15, largest variable index; NUM_CLA, 4, clause store entries; IMP_DEPTH, 4, implication FIFO entries.
REQ-002 Derived width: LW = $clog2(LIT_INDEX_MAX)+1; literals are signed LW-bit; value 0 = empty slot, sign = polarity.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 cla_wr_en / cla_wr_idx / cla_wr_data  in  1 / $clog2(NUM_CLA) / CLA_LENGTH*LW  clause store load port.
REQ-006 dec_valid / dec_lit / dec_ready  in / in / out  1 / LW / 1  decision literal handshake.
REQ-007 pe_litDec / pe_clause  out  LW / CLA_LENGTH*LW  drive to bcp_pe.
REQ-008 pe_imply, pe_imply_idx, pe_pr_clause, pe_done, pe_conflict  in  1, LW, CLA_LENGTH*LW, 1, 1  bcp_pe results, combinational with pe_* outputs.
REQ-009 imp_valid / imp_lit / imp_ready  out / out / in  1 / LW / 1  implied-literal output stream.
REQ-010 busy, conflict, sweep_done  out  1 each; conflict_idx  out  $clog2(NUM_CLA); conflict_clr  in  1.

Function
REQ-011 Clause store: NUM_CLA x CLA_LENGTH*LW registers plus one sat bit per entry.
REQ-012 cla_wr_en is honoured only in IDLE: writes entry, clears its sat bit; ignored in all other states.
REQ-013 FSM states: IDLE, SWEEP, DRAIN, CONFLICT.
REQ-014 IDLE: dec_ready=1, busy=0; dec_valid with dec_lit!=0 latches dec_lit, idx=0, next SWEEP.
REQ-015 IDLE, dec_valid with dec_lit==0: handshake completes, no sweep, sweep_done pulses the next cycle.
REQ-016 SWEEP: pe_litDec = latched literal; pe_clause = store[idx]; busy=1; dec_ready=0; one clause per cycle.
REQ-017 SWEEP, sat[idx]=1: PE results ignored, no writeback, idx advances.
REQ-018 SWEEP, pe_conflict=1 (sat[idx]=0): no writeback, conflict_idx<=idx, next CONFLICT; conflict overrides imply/done.
REQ-019 SWEEP otherwise: store[idx]<=pe_pr_clause; pe_done sets sat[idx]; pe_imply pushes pe_imply_idx into FIFO.
REQ-020 Stall: pe_imply=1 with FIFO full and no pop this cycle: no writeback, no push, idx held.
REQ-021 idx==NUM_CLA-1 processed without stall or conflict -> DRAIN.
REQ-022 DRAIN: busy=1; on FIFO empty -> IDLE, sweep_done=1 for exactly one cycle.
REQ-023 CONFLICT: conflict=1 and conflict_idx held, busy=1, FIFO pops still permitted; conflict_clr -> IDLE, FIFO flushed, store unchanged.
REQ-024 FIFO: imp_valid = not empty; imp_lit = head; pop on imp_valid&&imp_ready; push and pop in same cycle legal at any occupancy including full; order preserved.
REQ-025 pe_litDec and pe_clause drive 0 outside SWEEP.

Reset
REQ-026 reset asserted (any state, including mid-sweep): state IDLE, idx 0, FIFO empty, all store entries and sat bits 0, conflict 0, conflict_idx 0, sweep_done 0, imp_valid 0, busy 0, dec_ready 1 after deassertion.
REQ-027 Outputs take reset values asynchronously on reset assertion, not at the next edge.

Verification
REQ-028 Load {1,2,0},{-1,3,0},{-2,-3,0},{4,0,0}; dec 1; model PE -> entry0 sat, entry1 implies 3, sweep 4 cycles, imp_lit=3, sweep_done once.
REQ-029 Load {-1,0,0} in entry2, others sat-producing; dec 1 -> conflict=1, conflict_idx=2 held; conflict_clr -> IDLE, FIFO empty.
REQ-030 imp_ready=0, five implying clauses (NUM_CLA=5, IMP_DEPTH=4) -> idx stalls at 4, no writeback; raise imp_ready -> completes, lits popped in order.
REQ-031 Second decision after sweep: previously sat entries skipped (no writeback), pruned clauses presented, not originals.
REQ-032 Assert reset during SWEEP idx=2 with FIFO holding 2 entries -> all outputs at REQ-026 values immediately; cla_wr_en during SWEEP -> store unchanged.
